// File: rtl/vrf_read_arbiter.sv
// Round-robin arbiter sharing the single VRF read-request port among NUM_REQ requesters,
// with a registered issue stage and operand-buffer credit tracking.
`timescale 1ns/1ps
module vrf_read_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned REQ_W   = 2,
    parameter int unsigned VSEL_W  = 5,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*VSEL_W-1:0] req_vs1,
    input  logic [NUM_REQ*VSEL_W-1:0] req_vs2,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      vrf_ready,
    output logic                      vrf_rd_valid,
    output logic [VSEL_W-1:0]         vrf_vs1,
    output logic [VSEL_W-1:0]         vrf_vs2,
    output logic [REQ_W-1:0]          vrf_rd_tag,
    input  logic                      opbuff_pop,
    output logic [CNT_W-1:0]          credits,
    output logic                      busy,
    output logic                      err_underflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    state_t             state, state_next;
    logic [REQ_W-1:0]   rr_ptr;
    logic [REQ_W-1:0]   win;
    logic [REQ_W-1:0]   scan_idx;
    logic               win_found;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               pop_ok;
    logic               credit_ok;
    logic               slot_free;
    logic               accept;

    // Round-robin scan starting at rr_ptr; first valid requester wins.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = REQ_W'((32'(rr_ptr) + k) % NUM_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win       = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    assign pop_ok    = opbuff_pop && (cnt != '0);
    assign credit_ok = (cnt < MAX_CNT) || pop_ok;
    assign slot_free = (state == IDLE) || ((state == ISSUE) && vrf_ready);
    assign accept    = !RST && slot_free && credit_ok && win_found && (state != FULL);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        cnt_next = cnt;
        if (accept && !pop_ok) begin
            cnt_next = cnt + 1'b1;
        end else if (!accept && pop_ok) begin
            cnt_next = cnt - 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = ISSUE;
                end else if (!(|req_valid) && (cnt == MAX_CNT) && !opbuff_pop) begin
                    state_next = FULL;
                end
            end
            ISSUE: begin
                if (vrf_ready) begin
                    if (accept) begin
                        state_next = ISSUE;
                    end else begin
                        state_next = (cnt_next == MAX_CNT) ? FULL : IDLE;
                    end
                end
            end
            FULL: begin
                if (opbuff_pop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            cnt           <= '0;
            err_underflow <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (opbuff_pop && (cnt == '0)) begin
                err_underflow <= 1'b1;
            end
        end
    end

    // Issue register: payload and tag only move on accept, so they stay stable under backpressure.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr       <= '0;
            vrf_rd_valid <= 1'b0;
            vrf_vs1      <= '0;
            vrf_vs2      <= '0;
            vrf_rd_tag   <= '0;
        end else if (accept) begin
            rr_ptr       <= REQ_W'((32'(win) + 1) % NUM_REQ);
            vrf_rd_valid <= 1'b1;
            vrf_vs1      <= req_vs1[win*VSEL_W +: VSEL_W];
            vrf_vs2      <= req_vs2[win*VSEL_W +: VSEL_W];
            vrf_rd_tag   <= win;
        end else if ((state == ISSUE) && vrf_ready) begin
            vrf_rd_valid <= 1'b0;
        end
    end

    assign credits = MAX_CNT - cnt;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_vrf_read_arbiter.sv
// Directed-vector bench for vrf_read_arbiter: a cycle-level behavioural model checked every
// cycle, plus hand-computed literal expectations for each scenario.
`timescale 1ns/1ps
module tb_vrf_read_arbiter;

    localparam int NREQ = 4;
    localparam int MAXO = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [19:0] req_vs1 = {5'd24, 5'd17, 5'd10, 5'd3};
    logic [19:0] req_vs2 = {5'd30, 5'd21, 5'd12, 5'd7};
    logic [3:0]  req_ready;
    logic        vrf_ready = 1'b0;
    logic        vrf_rd_valid;
    logic [4:0]  vrf_vs1, vrf_vs2;
    logic [1:0]  vrf_rd_tag;
    logic        opbuff_pop = 1'b0;
    logic [2:0]  credits;
    logic        busy;
    logic        err_underflow;

    vrf_read_arbiter #(
        .NUM_REQ(4), .REQ_W(2), .VSEL_W(5), .MAX_OUT(4), .CNT_W(3)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_vs1(req_vs1), .req_vs2(req_vs2),
        .req_ready(req_ready),
        .vrf_ready(vrf_ready), .vrf_rd_valid(vrf_rd_valid),
        .vrf_vs1(vrf_vs1), .vrf_vs2(vrf_vs2), .vrf_rd_tag(vrf_rd_tag),
        .opbuff_pop(opbuff_pop), .credits(credits), .busy(busy),
        .err_underflow(err_underflow)
    );

    always #5 CLK = ~CLK;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model: outstanding count, one presentation slot, a "stalled on full" flag.
    int vs1_tab [4] = '{3, 10, 17, 24};
    int vs2_tab [4] = '{7, 12, 21, 30};
    int m_cnt, m_rr, m_tag, m_vs1, m_vs2;
    bit m_valid, m_full, m_err;
    int mw, mexp, mnew;
    bit many, mpop, mcred, mfree, macc;

    always @(negedge CLK) begin
        if (RST) begin
            m_cnt = 0; m_rr = 0; m_tag = 0; m_vs1 = 0; m_vs2 = 0;
            m_valid = 0; m_full = 0; m_err = 0;
            chk("rst_ready",   req_ready, 0);
            chk("rst_valid",   vrf_rd_valid, 0);
            chk("rst_busy",    busy, 0);
            chk("rst_credits", credits, MAXO);
            chk("rst_err",     err_underflow, 0);
        end else begin
            many = (req_valid != 0);
            mw = -1;
            for (int k = 0; k < NREQ; k++)
                if (mw < 0 && req_valid[(m_rr + k) % NREQ]) mw = (m_rr + k) % NREQ;
            mpop  = opbuff_pop && (m_cnt > 0);
            mcred = (m_cnt < MAXO) || mpop;
            mfree = m_valid ? vrf_ready : !m_full;
            macc  = many && mfree && mcred;
            mexp  = macc ? (1 << mw) : 0;

            chk("m_ready",   req_ready, mexp);
            chk("m_valid",   vrf_rd_valid, int'(m_valid));
            chk("m_vs1",     vrf_vs1, m_vs1);
            chk("m_vs2",     vrf_vs2, m_vs2);
            chk("m_tag",     vrf_rd_tag, m_tag);
            chk("m_credits", credits, MAXO - m_cnt);
            chk("m_busy",    busy, int'(m_valid || m_full));
            chk("m_err",     err_underflow, int'(m_err));
            assert (int'(credits) <= MAXO)
                else $error("FAIL cnt_bound: credits %0d above %0d", credits, MAXO);

            mnew = m_cnt + (macc ? 1 : 0) - (mpop ? 1 : 0);
            if (opbuff_pop && m_cnt == 0) m_err = 1;
            if (macc) begin
                m_valid = 1; m_tag = mw; m_vs1 = vs1_tab[mw]; m_vs2 = vs2_tab[mw];
                m_rr = (mw + 1) % NREQ;
            end else if (m_valid && vrf_ready) begin
                m_valid = 0;
                m_full  = (mnew == MAXO);
            end else if (!m_valid && !m_full) begin
                m_full = !many && (m_cnt == MAXO) && !opbuff_pop;
            end else if (m_full && opbuff_pop) begin
                m_full = 0;
            end
            m_cnt = mnew;
        end
    end

    task automatic cyc(input logic [3:0] v, input logic r, input logic p);
        @(posedge CLK); #1;
        req_valid = v; vrf_ready = r; opbuff_pop = p;
        @(negedge CLK); #1;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1; req_valid = '0; vrf_ready = 0; opbuff_pop = 0;
        @(posedge CLK); @(posedge CLK); #1;
        RST = 0;
    endtask

    int tag_seq [5] = '{0, 1, 2, 3, 0};

    initial begin
        repeat (2) @(posedge CLK);
        #1 RST = 0;

        // single request
        cyc(4'b0001, 1, 0);
        chk("t1_ready", req_ready, 1);
        chk("t1_credits_before", credits, 4);
        cyc(4'b0000, 1, 0);
        chk("t1_valid", vrf_rd_valid, 1);
        chk("t1_vs1", vrf_vs1, 3);
        chk("t1_vs2", vrf_vs2, 7);
        chk("t1_tag", vrf_rd_tag, 0);
        chk("t1_credits_after", credits, 3);

        // round robin with steady pops
        do_reset();
        cyc(4'b1111, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(4'b1111, 1, 1);
            chk("t2_tag", vrf_rd_tag, tag_seq[i]);
            chk("t2_credits", credits, 3);
        end

        // backpressure
        do_reset();
        cyc(4'b0100, 1, 0);
        chk("t3_first", req_ready, 4'b0100);
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 0, 0);
            chk("t3_hold_tag", vrf_rd_tag, 2);
            chk("t3_hold_vs1", vrf_vs1, 17);
            chk("t3_hold_valid", vrf_rd_valid, 1);
            chk("t3_hold_ready", req_ready, 0);
        end
        cyc(4'b1111, 1, 0);
        chk("t3_release", req_ready, 4'b1000);
        cyc(4'b0000, 1, 0);
        chk("t3_next_tag", vrf_rd_tag, 3);
        chk("t3_next_vs2", vrf_vs2, 30);

        // credit exhaustion
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(4'b0001, 1, 0);
            chk("t4_accept", req_ready, 1);
        end
        cyc(4'b0001, 1, 0);
        chk("t4_no_credit", req_ready, 0);
        chk("t4_credits0", credits, 0);
        cyc(4'b0001, 1, 0);
        chk("t4_full_ready", req_ready, 0);
        chk("t4_full_busy", busy, 1);
        chk("t4_full_valid", vrf_rd_valid, 0);
        cyc(4'b0001, 1, 1);
        chk("t4_pop_cycle_ready", req_ready, 0);
        cyc(4'b0001, 1, 0);
        chk("t4_reaccept", req_ready, 1);
        chk("t4_credits1", credits, 1);
        cyc(4'b0000, 1, 0);
        chk("t4_credits_end", credits, 0);

        // simultaneous accept+pop, then underflow
        do_reset();
        repeat (3) cyc(4'b0001, 1, 0);
        cyc(4'b0001, 1, 1);
        chk("t5_acc_pop_ready", req_ready, 1);
        chk("t5_credits_before", credits, 1);
        cyc(4'b0000, 1, 1);
        chk("t5_credits_unchanged", credits, 1);
        cyc(4'b0000, 1, 1);
        chk("t5_drain2", credits, 2);
        cyc(4'b0000, 1, 1);
        cyc(4'b0000, 1, 1);
        chk("t5_empty", credits, 4);
        chk("t5_err_before", err_underflow, 0);
        cyc(4'b0000, 1, 0);
        chk("t5_err_set", err_underflow, 1);
        chk("t5_credits_sat", credits, 4);
        repeat (3) cyc(4'b0000, 0, 0);
        chk("t5_err_sticky", err_underflow, 1);

        // asynchronous reset mid-issue
        do_reset();
        cyc(4'b0001, 1, 0);
        cyc(4'b0000, 0, 0);
        chk("t6_issue_valid", vrf_rd_valid, 1);
        chk("t6_issue_busy", busy, 1);
        #2;
        req_valid = 4'b1111;
        RST = 1;
        #1;
        chk("t6_async_valid", vrf_rd_valid, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_credits", credits, 4);
        chk("t6_async_ready", req_ready, 0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 0; req_valid = '0;
        cyc(4'b1000, 1, 0);
        chk("t6_after_ready", req_ready, 4'b1000);
        cyc(4'b1111, 1, 0);
        chk("t6_rr_wrap", req_ready, 4'b0001);
        cyc(4'b0000, 1, 0);
        chk("t6_tag", vrf_rd_tag, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
